weight_fifo_bank: RTL and testbench
===================================

WEIGHT_FIFO_BANK -- requirements
Module: weight_fifo_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per weight.
REQ-002 SHALL have parameter COLS, default 16, number of column FIFOs; equals the MMU width and the width of the fifo-enable vector.
REQ-003 SHALL have parameter DEPTH, default 16, entries per column; power of two.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous flush of all columns.
- wr_en  in  1  push one weight row into all columns.
- wr_data  in  DATA_WIDTH*COLS  row; column c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- wr_ready  out  1  high when no column is full.
- rd_en  in  COLS  per-column pop; driven by the fifo-enable vector of the load controller.
- rd_data  out  DATA_WIDTH*COLS  per-column head, toward the MMU weight inputs.
- col_valid  out  COLS  column non-empty.
- all_empty  out  1  every column empty.
- err_ovf  out  1  sticky overflow flag.
- err_unf  out  1  sticky underflow flag.

Function
REQ-005 Each column SHALL be a circular buffer with rd_ptr and wr_ptr of width $clog2(DEPTH), plus count of width $clog2(DEPTH+1); pointers SHALL wrap DEPTH-1 -> 0.
REQ-006 Writes SHALL be accepted only when wr_en && wr_ready. On acceptance, every column SHALL store its slice at wr_ptr and increment wr_ptr, effective the next edge.
REQ-007 wr_ready SHALL be combinational: low if any column count == DEPTH.
REQ-008 rd_data slice c SHALL be first-word-fall-through: mem[rd_ptr] when count != 0, else all zero.
REQ-009 Column c SHALL pop when rd_en[c] && col_valid[c]. A pop advances rd_ptr at the next edge.
REQ-010 Simultaneous accepted write and pop on one column: count unchanged, both pointers advance.
REQ-011 Write into an empty column while rd_en[c] is high: write accepted, no pop, rd_data[c] = 0 that cycle, head visible the next cycle.
REQ-012 rd_en[c] on an empty column SHALL be ignored: no pointer change.
REQ-013 col_valid[c] SHALL equal (count != 0); all_empty SHALL equal ~|col_valid. Both combinational from registered state.
REQ-014 clear SHALL zero all pointers and counts at the next edge. It overrides a same-cycle write or pop. Memory contents are not cleared.
REQ-015 Columns SHALL drain independently, so staggered rd_en patterns (MSB-first ramp up, then ramp down) leave differing counts per column.

Reset
REQ-016 During reset, all pointers, counts, err_ovf and err_unf SHALL be 0 at the next edge.
REQ-017 After reset: wr_ready=1, col_valid=0, all_empty=1, rd_data=0.
REQ-018 Reset asserted mid-transfer SHALL discard all entries. Reset takes priority over clear, wr_en and rd_en.
REQ-019 Memory arrays SHALL NOT be reset.

Configuration
REQ-020 Macro WEIGHT_FIFO_BANK_ERR_EN defined:
- err_ovf SHALL set on wr_en && !wr_ready.
- err_unf SHALL set on any rd_en[c] && !col_valid[c].
- Both flags SHALL clear only on reset or clear.
REQ-021 Macro undefined: err_ovf and err_unf SHALL be tied 0 and no error logic SHALL be synthesized.

Structure
REQ-022 A shared package SHALL hold the default DATA_WIDTH, COLS and DEPTH constants, shared with the load controller and MMU.
REQ-023 One sub-module, weight_fifo_col, SHALL implement a single column (memory, pointers, count, FWFT output). The top SHALL instantiate COLS copies via generate and hold the common wr_ready and error logic.

Verification
REQ-024 Reset, then 16 writes with row k = {COLS{8'(k)}}, then rd_en=16'hFFFF for 16 cycles -> each column emits 0..15 in order; all_empty=1 afterward.
REQ-025 Write 16 rows, then 17th wr_en -> wr_ready=0, 17th row dropped; with ERR_EN, err_ovf=1 sticky.
REQ-026 Fill 16 rows, drive staggered rd_en 16'h8000, 16'hC000 ... 16'hFFFF, then shift-down to 16'h0000 -> column 15 drains first; every column outputs 0..15; all_empty=1 at the end.
REQ-027 Column count 0: simultaneous wr_en and rd_en[0] -> rd_data[0]=0 that cycle, count=1, head valid the next cycle.
REQ-028 Count 8 on all columns: simultaneous wr_en and rd_en=16'hFFFF for 20 cycles -> counts stay 8, pointers wrap, data stays in order.
REQ-029 Reset or clear asserted mid-drain with count 5 -> next cycle all_empty=1 and rd_data=0; with ERR_EN, a prior err_unf is cleared.

Source files
------------

// File: rtl/weight_fifo_bank_pkg.sv
// weight_fifo_bank_pkg: default weight-path dimensions shared by the FIFO bank, load controller and MMU
package weight_fifo_bank_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_COLS       = 16;
  localparam int DEF_DEPTH      = 16;
endpackage

// File: rtl/weight_fifo_col.sv
// weight_fifo_col: one first-word-fall-through column (memory, pointers, count)
module weight_fifo_col
  import weight_fifo_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_wr_acc,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_valid,
  output logic                  o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_pop;
  assign o_valid   = r_count != '0;
  assign o_full    = r_count == CW'(DEPTH);
  assign w_pop     = i_rd_en && o_valid;
  assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;
  always_ff @(posedge clk)
    if (i_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_wr_acc);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(i_wr_acc) - CW'(w_pop);
    end
endmodule

// File: rtl/weight_fifo_bank.sv
// weight_fifo_bank: COLS lock-step-written, independently drained weight columns.
// Define WEIGHT_FIFO_BANK_ERR_EN to build the sticky overflow/underflow flags.
module weight_fifo_bank
  import weight_fifo_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COLS       = DEF_COLS,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH*COLS-1:0] wr_data,
  output logic                       wr_ready,
  input  logic [COLS-1:0]            rd_en,
  output logic [DATA_WIDTH*COLS-1:0] rd_data,
  output logic [COLS-1:0]            col_valid,
  output logic                       all_empty,
  output logic                       err_ovf,
  output logic                       err_unf
);
  logic [COLS-1:0] w_full;
  logic            w_wr_acc;
  assign wr_ready  = ~|w_full;
  assign w_wr_acc  = wr_en && wr_ready;
  assign all_empty = ~|col_valid;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    weight_fifo_col #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_col (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (clear),
      .i_wr_acc  (w_wr_acc),
      .i_wr_data (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .i_rd_en   (rd_en[c]),
      .o_rd_data (rd_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .o_valid   (col_valid[c]),
      .o_full    (w_full[c])
    );
  end
`ifdef WEIGHT_FIFO_BANK_ERR_EN
  logic r_err_ovf, r_err_unf;
  always_ff @(posedge clk)
    if (reset || clear) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (wr_en && !wr_ready) r_err_ovf <= 1'b1;
      if (|(rd_en & ~col_valid)) r_err_unf <= 1'b1;
    end
  assign err_ovf = r_err_ovf;
  assign err_unf = r_err_unf;
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif
endmodule

// File: tb/tb_weight_fifo_bank.sv
// tb_weight_fifo_bank: vector table, directed corner sequences and random traffic vs a queue model
module tb_weight_fifo_bank;
  import weight_fifo_bank_pkg::*;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int C  = DEF_COLS;
  localparam int D  = DEF_DEPTH;
  localparam int W  = DW * C;

  logic          clk = 1'b0;
  logic          reset, clear, wr_en, wr_ready, all_empty, err_ovf, err_unf;
  logic [W-1:0]  wr_data, rd_data;
  logic [C-1:0]  rd_en, col_valid;

  always #5 clk = ~clk;

  weight_fifo_bank dut (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data), .col_valid(col_valid),
    .all_empty(all_empty), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  logic [DW-1:0] q [C][$];
  bit            m_ovf, m_unf;
  int            n_chk = 0, n_fail = 0;
  logic [W-1:0]  s_rd;
  logic [C-1:0]  s_v;
  logic          s_rdy, s_ae, s_unf;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive, compare against the model before the edge, then advance the model.
  task automatic step(input bit rs, input bit cl, input bit we, input logic [W-1:0] wd,
                      input logic [C-1:0] re, input bit ck);
    logic [W-1:0] e_rd;
    logic [C-1:0] e_v;
    bit           e_rdy;
    @(negedge clk);
    reset = rs; clear = cl; wr_en = we; wr_data = wd; rd_en = re;
    e_rd = '0; e_v = '0; e_rdy = 1'b1;
    for (int c = 0; c < C; c++) begin
      if (q[c].size() != 0) begin
        e_v[c] = 1'b1;
        e_rd[c*DW +: DW] = q[c][0];
      end
      if (q[c].size() == D) e_rdy = 1'b0;
    end
    #1;
    s_rd = rd_data; s_v = col_valid; s_rdy = wr_ready; s_ae = all_empty; s_unf = err_unf;
    if (ck) begin
      chk("wr_ready", W'(wr_ready), W'(e_rdy));
      chk("rd_data", rd_data, e_rd);
      chk("col_valid", W'(col_valid), W'(e_v));
      chk("all_empty", W'(all_empty), W'(e_v == '0));
      chk("err_ovf", W'(err_ovf), W'(m_ovf));
      chk("err_unf", W'(err_unf), W'(m_unf));
    end
    @(posedge clk);
    if (rs || cl) begin
      for (int c = 0; c < C; c++) q[c].delete();
      m_ovf = 0; m_unf = 0;
    end else begin
`ifdef WEIGHT_FIFO_BANK_ERR_EN
      if (we && !e_rdy) m_ovf = 1;
      if (|(re & ~e_v)) m_unf = 1;
`endif
      for (int c = 0; c < C; c++) begin
        if (re[c] && e_v[c]) void'(q[c].pop_front());
        if (we && e_rdy) q[c].push_back(wd[c*DW +: DW]);
      end
    end
  endtask

  function automatic logic [W-1:0] row(input int k);
    return {C{DW'(k)}};
  endfunction

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    bit           cl, we;
    logic [W-1:0] wd;
    logic [C-1:0] re;
    logic [W-1:0] e_rd;
    logic [C-1:0] e_v;
    bit           e_rdy, e_ae;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{0, 1, row(8'h11), 16'h0001, '0, '0, 1, 1};
    tbl[1] = '{0, 0, '0, '0, row(8'h11), 16'hFFFF, 1, 0};
    tbl[2] = '{0, 1, row(8'h22), 16'h0001, row(8'h11), 16'hFFFF, 1, 0};
    tbl[3] = '{0, 0, '0, '0, {{(C-1){8'h11}}, 8'h22}, 16'hFFFF, 1, 0};
    tbl[4] = '{0, 0, '0, 16'hFFFF, {{(C-1){8'h11}}, 8'h22}, 16'hFFFF, 1, 0};
    tbl[5] = '{0, 0, '0, 16'h0001, {{(C-1){8'h22}}, 8'h00}, 16'hFFFE, 1, 0};
    tbl[6] = '{1, 1, row(8'h33), '0, {{(C-1){8'h22}}, 8'h00}, 16'hFFFE, 1, 0};
    tbl[7] = '{0, 0, '0, '0, '0, '0, 1, 1};

    step(1, 0, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, tbl[i].cl, tbl[i].we, tbl[i].wd, tbl[i].re, 1);
      chk($sformatf("tbl%0d_rd_data", i), s_rd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_col_valid", i), W'(s_v), W'(tbl[i].e_v));
      chk($sformatf("tbl%0d_wr_ready", i), W'(s_rdy), W'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_all_empty", i), W'(s_ae), W'(tbl[i].e_ae));
    end

    // fill 16 rows, then drain all columns together
    step(1, 0, 0, '0, '0, 1);
    for (int k = 0; k < 16; k++) step(0, 0, 1, row(k), '0, 1);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, '0, 16'hFFFF, 1);
      chk("drain_order", s_rd, row(k));
    end
    step(0, 0, 0, '0, '0, 1);
    chk("drain_all_empty", W'(s_ae), W'(1));

    // overflow: 17th write dropped
    for (int k = 0; k < 16; k++) step(0, 0, 1, row(k), '0, 1);
    step(0, 0, 1, row(8'hAA), '0, 1);
    chk("full_wr_ready", W'(s_rdy), W'(0));
    step(0, 0, 0, '0, '0, 1);
    for (int k = 0; k < 16; k++) step(0, 0, 0, '0, 16'hFFFF, 1);
    step(0, 0, 0, '0, '0, 1);
    chk("ovf_drop_empty", W'(s_ae), W'(1));

    // staggered ramp up from the MSB column, then ramp down
    step(1, 0, 0, '0, '0, 1);
    for (int k = 0; k < 16; k++) step(0, 0, 1, row(k), '0, 1);
    for (int i = 1; i <= 16; i++) step(0, 0, 0, '0, C'(16'hFFFF << (16 - i)), 1);
    for (int i = 1; i <= 16; i++) step(0, 0, 0, '0, C'(16'hFFFF >> i), 1);
    step(0, 0, 0, '0, '0, 1);
    chk("stagger_all_empty", W'(s_ae), W'(1));

    // steady state at count 8 with concurrent write and pop
    for (int k = 0; k < 8; k++) step(0, 0, 1, row(k), '0, 1);
    for (int k = 8; k < 28; k++) begin
      step(0, 0, 1, row(k), 16'hFFFF, 1);
      chk("steady_head", s_rd, row(k - 8));
    end
    for (int k = 20; k < 28; k++) begin
      step(0, 0, 0, '0, 16'hFFFF, 1);
      chk("steady_tail", s_rd, row(k));
    end

    // reset mid-drain at count 5
    for (int k = 0; k < 8; k++) step(0, 0, 1, row(k), '0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, '0, 16'hFFFF, 1);
    step(1, 0, 0, '0, 16'hFFFF, 1);
    step(0, 0, 0, '0, '0, 1);
    chk("rst_mid_empty", W'(s_ae), W'(1));
    chk("rst_mid_rd", s_rd, '0);

    // clear mid-drain at count 5, after a prior underflow
    step(0, 0, 0, '0, 16'h0003, 1);
    for (int k = 0; k < 8; k++) step(0, 0, 1, row(k), '0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, '0, 16'hFFFF, 1);
    step(0, 1, 0, '0, 16'hFFFF, 1);
    step(0, 0, 0, '0, '0, 1);
    chk("clr_mid_empty", W'(s_ae), W'(1));
    chk("clr_mid_rd", s_rd, '0);
    chk("clr_mid_unf", W'(s_unf), W'(0));

    // random traffic: write-heavy phase, then read-heavy phase
    for (int i = 0; i < 600; i++) begin
      bit rs, cl, we;
      logic [C-1:0] re;
      rs = ($urandom_range(0, 199) == 0);
      cl = ($urandom_range(0, 99) == 0);
      we = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      re = (i < 300) ? C'($urandom & $urandom) : C'($urandom | $urandom);
      step(rs, cl, we, rnd_row(), re, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
